// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the default operand width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the multiply/divide datapath: radix-2 shift-add for
// multiply, one restoring quotient bit for divide. Purely combinational.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: {acc_hi, acc_lo} holds {partial product, remaining multiplier bits}.
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        nxt_hi  = sum[WIDTH:1];
        nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit, WIDTH cycles per operation.
// Define MULDIV_SIGNED_EN to make OP_MULT/OP_DIV signed; otherwise they act unsigned.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             accept, last, is_div_op;
    logic             is_div, zero_div;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] quo, rem, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_SIGNED_EN
    logic             signed_op, a_neg, b_neg;
    logic             neg_q, neg_r;
`endif

    // Handshake: start is only a request; it is taken when accept is high
    // (IDLE or DONE), and silently ignored while busy.
    assign accept    = start && (state == IDLE || state == DONE);
    assign last      = (cnt == LAST);
    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (flush) state_nxt = IDLE;
                     else if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == CALC);
        done      = (state == DONE);
        state_dbg = state;
    end

    always_comb begin
`ifdef MULDIV_SIGNED_EN
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op && a[WIDTH-1];
        b_neg     = signed_op && b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
`else
        mag_a     = a;
        mag_b     = b;
`endif
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div (is_div),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    // Final result is formed from the last iteration's output so HI/LO load on that same edge.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        prod = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
        quo  = neg_q ? -nxt_lo : nxt_lo;
        rem  = neg_r ? -nxt_hi : nxt_hi;
`else
        prod = {nxt_hi, nxt_lo};
        quo  = nxt_lo;
        rem  = nxt_hi;
`endif
        res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? (zero_div ? '1 : quo) : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            zero_div <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else if (accept) begin
            cnt      <= '0;
            is_div   <= is_div_op;
            zero_div <= is_div_op && (b == '0);
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            opnd     <= mag_b;
            div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
`endif
        end else if (state == CALC) begin
            if (!flush) begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    hi       <= res_hi;
                    lo       <= res_lo;
                    div_zero <= zero_div;
                end
            end
        end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width, HI width and LO width; legal values are even and 8..64.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: reset; synchronous, active-high.
REQ-004 Port start, input, 1: request a new operation; sampled only in IDLE or DONE.
REQ-005 Port op, input, 2: operation select (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
REQ-006 Port a, input, WIDTH: rs operand (multiplicand / dividend).
REQ-007 Port b, input, WIDTH: rt operand (multiplier / divisor).
REQ-008 Port flush, input, 1: abort the in-flight operation (pipeline flush or exception).
REQ-009 Port mthi / mtlo, input, 1 each: direct write of wdata into HI / LO.
REQ-010 Port wdata, input, WIDTH: data for mthi / mtlo.
REQ-011 Port busy, output, 1: high while the FSM is in CALC; the pipeline stalls MFHI/MFLO and new mul/div on it.
REQ-012 Port done, output, 1: one-cycle pulse marking that HI/LO hold a new result.
REQ-013 Port div_zero, output, 1: sticky flag set by a divide with b==0; cleared by the next accepted start.
REQ-014 Port hi / lo, output, WIDTH: architectural HI / LO registers.

Function
REQ-015 The FSM SHALL have three states, IDLE, CALC and DONE; transitions:
- IDLE/DONE -> CALC on start;
- DONE -> IDLE otherwise;
- CALC -> DONE when the iteration counter reaches WIDTH-1;
- CALC -> IDLE on flush.
REQ-016 Operand latch: at the accepting edge, store |a| and |b| for signed ops, raw values for unsigned ops, plus the result sign and the remainder sign.
REQ-017 Multiply SHALL be radix-2 shift-add, one bit per CALC cycle, 2*WIDTH-bit product.
REQ-018 Divide SHALL be restoring, one quotient bit per CALC cycle.
REQ-019 Latency: start sampled at edge E0; CALC occupies WIDTH cycles; HI/LO load at edge E_WIDTH; done is high the following cycle.
REQ-020 Multiply results: HI = product[2W-1:W], LO = product[W-1:0], two's-complement negated when the signs differ.
REQ-021 Divide results: LO = quotient (negated if the signs differ), HI = remainder carrying the sign of a.
REQ-022 Divide by zero: no iteration skip; HI = a, LO = all ones, and div_zero is set.
REQ-023 start while busy SHALL be ignored; start in DONE is accepted (back-to-back ops with no IDLE cycle).
REQ-024 flush in CALC SHALL return the FSM to IDLE next edge with HI/LO unchanged and no done pulse; flush in IDLE/DONE has no effect.
REQ-025 mthi/mtlo SHALL be ignored while busy.
REQ-026 mthi/mtlo SHALL be applied at the edge when not busy, except on the accepting edge of a start, where start wins and the writes are dropped.
REQ-027 mthi and mtlo in the same cycle SHALL write both registers.
REQ-028 A signed overflow case (most-negative / -1) SHALL produce LO = most-negative and HI = 0 with no flag.

Reset
REQ-029 On rst the FSM SHALL go to IDLE, and busy, done, div_zero, hi and lo SHALL all be 0.
REQ-030 rst SHALL have priority over flush, start and mt writes, including mid-CALC.

Configuration
REQ-031 With MULDIV_SIGNED_EN defined: OP_MULT and OP_DIV perform signed arithmetic as specified above.
REQ-032 Without MULDIV_SIGNED_EN: OP_MULT and OP_DIV execute as OP_MULTU and OP_DIVU, and the sign-correction logic is absent.

Structure
REQ-033 Package muldiv_pkg SHALL hold the op encodings (OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3), the state typedef and the DEFAULT_WIDTH constant.
REQ-034 Sub-module muldiv_iter SHALL hold the per-cycle add/subtract-and-shift datapath; muldiv_unit holds the FSM, counter, sign handling and HI/LO.

Verification (WIDTH=32, MULDIV_SIGNED_EN defined)
REQ-035 MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after start, HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 MULT with a=-2, b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; DIV with a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 DIVU with a=100, b=0 -> div_zero=1, HI=100, LO=0xFFFFFFFF; next DIVU with a=100, b=7 -> div_zero=0, LO=14, HI=2.
REQ-038 flush 10 cycles into a MULTU with HI/LO previously 0x11/0x22 -> busy drops next cycle, no done, HI/LO stay 0x11/0x22.
REQ-039 Start raised again during DONE, and mtlo asserted while busy -> the second op is accepted with no gap, and the mtlo is ignored.
REQ-040 rst asserted mid-CALC -> the next cycle shows all outputs 0 and the FSM in IDLE.
